// File: rtl/dd_capture_pkg.sv
// Shared constants for the ADC capture path.
package dd_capture_pkg;

    localparam int unsigned ADC_WIDTH          = 10;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 12;
    localparam int unsigned DEFAULT_BURST_LEN  = 1024;

endpackage

// File: rtl/adc_sample_fifo_sample_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read, no reset.
module sample_ram
    import dd_capture_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_DEPTH_LOG2,
    parameter int unsigned DATA_WIDTH = ADC_WIDTH
) (
    input  logic                  inclk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Read-first: a pop from the slot being overwritten (full FIFO) returns the old word.
    always_ff @(posedge inclk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO: capture stage, optional test ramp, burst-ready flag and sticky overflow.
module adc_sample_fifo
    import dd_capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN
) (
    input  logic                 inclk,
    input  logic                 nReset,
    input  logic [ADC_WIDTH-1:0] adcData,
    input  logic                 collectData,
    input  logic                 testMode,
    input  logic                 readData,
    output logic                 dataAvailable,
    output logic [ADC_WIDTH-1:0] dataOut,
    output logic                 overflow,
    output logic [DEPTH_LOG2:0]  fillLevel
);

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] BURST_LEVEL = (DEPTH_LOG2 + 1)'(BURST_LEN);

    logic                  r_collect;
    logic [ADC_WIDTH-1:0]  r_cap_data;
    logic [ADC_WIDTH-1:0]  r_ramp;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_fill;
    logic                  r_overflow;
    logic                  r_avail;
    logic                  r_out_valid;

    logic                  w_start;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic [ADC_WIDTH-1:0]  w_ramp_val;
    logic [ADC_WIDTH-1:0]  w_ram_q;

    always_comb begin
        w_start    = collectData & ~r_collect;
        w_full     = (r_fill == FULL_LEVEL);
        // A run restart flushes the FIFO, so a read in that cycle is dropped.
        w_rd       = readData & (r_fill != '0) & ~w_start;
        w_wr       = r_collect & (~w_full | w_rd);
        w_drop     = r_collect & w_full & ~w_rd;
        w_ramp_val = w_start ? '0 : r_ramp;
    end

    // r_collect doubles as the capture-stage valid and the previous-collectData edge detector.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_collect  <= 1'b0;
            r_cap_data <= '0;
            r_ramp     <= '0;
        end else begin
            r_collect <= collectData;
            if (collectData) begin
                r_cap_data <= testMode ? w_ramp_val : adcData;
                r_ramp     <= w_ramp_val + 1'b1;
            end
        end
    end

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_overflow  <= 1'b0;
            r_avail     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_avail     <= (r_fill >= BURST_LEVEL);
            r_out_valid <= r_out_valid | w_rd;
            if (w_start) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_fill     <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_rd) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                unique case ({w_wr, w_rd})
                    2'b10:   r_fill <= r_fill + 1'b1;
                    2'b01:   r_fill <= r_fill - 1'b1;
                    default: r_fill <= r_fill;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    sample_ram #(
        .ADDR_WIDTH (DEPTH_LOG2),
        .DATA_WIDTH (ADC_WIDTH)
    ) u_ram (
        .inclk   (inclk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (r_cap_data),
        .i_re    (w_rd),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    // The RAM has no reset, so dataOut reads as zero until the first pop after reset.
    assign dataOut       = r_out_valid ? w_ram_q : '0;
    assign dataAvailable = r_avail;
    assign overflow      = r_overflow;
    assign fillLevel     = r_fill;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Self-checking bench for adc_sample_fifo against a queue-based reference model.
module tb_adc_sample_fifo;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BURST = 10;

    logic       inclk = 1'b0;
    logic       nReset = 1'b1;
    logic [9:0] adcData = '0;
    logic       collectData = 1'b0;
    logic       testMode = 1'b0;
    logic       readData = 1'b0;
    logic       dataAvailable;
    logic [9:0] dataOut;
    logic       overflow;
    logic [DL2:0] fillLevel;

    always #5 inclk = ~inclk;

    adc_sample_fifo #(
        .DEPTH_LOG2 (DL2),
        .BURST_LEN  (BURST)
    ) dut (
        .inclk         (inclk),
        .nReset        (nReset),
        .adcData       (adcData),
        .collectData   (collectData),
        .testMode      (testMode),
        .readData      (readData),
        .dataAvailable (dataAvailable),
        .dataOut       (dataOut),
        .overflow      (overflow),
        .fillLevel     (fillLevel)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [9:0] m_q[$];
    bit         m_pend_valid;
    logic [9:0] m_pend_data;
    bit         m_prev_col;
    int         m_ramp;
    bit         m_ovf;
    bit         m_avail;
    logic [9:0] m_out;
    int         m_pops;
    bit         m_popped;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend_valid = 0;
        m_pend_data  = '0;
        m_prev_col   = 0;
        m_ramp       = 0;
        m_ovf        = 0;
        m_avail      = 0;
        m_out        = '0;
        m_pops       = 0;
        m_popped     = 0;
    endtask

    // One rising edge: a new run flushes everything; otherwise pop, then push the pending capture.
    task automatic model_edge(input bit col, input bit tm, input bit rd, input logic [9:0] adc);
        int  sz    = m_q.size();
        bit  start = col && !m_prev_col;
        int  idx;
        m_popped = 0;
        m_avail  = (sz >= BURST);
        if (start) begin
            m_q.delete();
            m_ovf  = 0;
            m_pops = 0;
        end else begin
            if (rd && sz > 0) begin
                m_out = m_q.pop_front();
                m_pops++;
                m_popped = 1;
            end
            if (m_pend_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_data);
                else m_ovf = 1;
            end
        end
        m_pend_valid = col;
        if (col) begin
            idx         = start ? 0 : m_ramp;
            m_pend_data = tm ? 10'(idx % 1024) : adc;
            m_ramp      = idx + 1;
        end
        m_prev_col = col;
    endtask

    task automatic check_outputs();
        check_eq("fillLevel", 32'(fillLevel), 32'(m_q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("dataAvailable", 32'(dataAvailable), 32'(m_avail));
        check_eq("dataOut", 32'(dataOut), 32'(m_out));
    endtask

    // Called at a falling edge; drives inputs, advances one cycle, checks at the next falling edge.
    task automatic tick(input bit col, input bit tm, input bit rd, input logic [9:0] adc);
        collectData = col;
        testMode    = tm;
        readData    = rd;
        adcData     = adc;
        @(posedge inclk);
        model_edge(col, tm, rd, adc);
        @(negedge inclk);
        check_outputs();
    endtask

    task automatic apply_reset(input bit hold_col);
        nReset      = 1'b0;
        collectData = hold_col;
        readData    = 1'b0;
        #1;
        model_reset();
        check_eq("rst_fill", 32'(fillLevel), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_avail", 32'(dataAvailable), 32'd0);
        check_eq("rst_dout", 32'(dataOut), 32'd0);
        @(negedge inclk);
        @(negedge inclk);
        nReset = 1'b1;
    endtask

    initial begin
        logic [9:0] saved;
        bit col_r, tm_r;
        model_reset();
        @(negedge inclk);
        apply_reset(1'b0);

        // Overflow: 20 captures into a 16-deep FIFO
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 10'($urandom));
        check_eq("ovf_sat_level", 32'(fillLevel), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, 1'b1, 10'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 10'($urandom));
        check_eq("ovf_clear", 32'(overflow), 32'd0);
        check_eq("ovf_clear_level", 32'(fillLevel), 32'd0);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 24 && m_q.size() < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 10'($urandom));
        tick(1'b1, 1'b0, 1'b1, 10'($urandom));
        check_eq("full_rw_level", 32'(fillLevel), 32'd16);
        check_eq("full_rw_ovf", 32'(overflow), 32'd0);

        // Empty reads, then empty read with concurrent write
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, 10'd0);
        saved = dataOut;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 10'd0);
        check_eq("empty_rd_level", 32'(fillLevel), 32'd0);
        check_eq("empty_rd_hold", 32'(dataOut), 32'(saved));
        tick(1'b1, 1'b0, 1'b1, 10'h0AA);
        tick(1'b1, 1'b0, 1'b1, 10'h0BB);
        check_eq("empty_rd_wr", 32'(fillLevel), 32'd1);

        // ADC path
        tick(1'b0, 1'b0, 1'b1, 10'd0);
        tick(1'b0, 1'b0, 1'b1, 10'd0);
        tick(1'b1, 1'b0, 1'b0, 10'h3FF);
        tick(1'b1, 1'b0, 1'b0, 10'h155);
        tick(1'b0, 1'b0, 1'b0, 10'h000);
        tick(1'b0, 1'b0, 1'b1, 10'h000);
        check_eq("adc_word0", 32'(dataOut), 32'h3FF);
        tick(1'b0, 1'b0, 1'b1, 10'h000);
        check_eq("adc_word1", 32'(dataOut), 32'h155);

        // Ramp with concurrent draining, across the 1023 -> 0 wrap
        tick(1'b0, 1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 1040; i++) begin
            tick(1'b1, 1'b1, (i >= 5), 10'($urandom));
            if (m_popped && m_pops == 1024) check_eq("ramp_last", 32'(dataOut), 32'd1023);
            if (m_popped && m_pops == 1025) check_eq("ramp_wrap", 32'(dataOut), 32'd0);
        end

        // Mid-run reset with collectData held through release
        tick(1'b0, 1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 10'd0);
        apply_reset(1'b1);
        tick(1'b1, 1'b0, 1'b0, 10'h123);
        check_eq("post_rst_level0", 32'(fillLevel), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 10'h124);
        check_eq("post_rst_level1", 32'(fillLevel), 32'd1);

        // Randomized traffic
        col_r = 1'b0;
        tm_r  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) col_r = ~col_r;
            if ($urandom_range(0, 63) == 0) tm_r = ~tm_r;
            if ($urandom_range(0, 599) == 0) apply_reset(1'($urandom_range(0, 1)));
            tick(col_r, tm_r, 1'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1)),
                 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
